// File: rtl/usb_endp_fifo_mux_if.sv
// Engine-side and endpoint-FIFO-side signals of the USB endpoint FIFO multiplexer.
// master: packet engines plus per-endpoint FIFOs; slave: the multiplexer itself.
interface usb_endp_fifo_mux_if #(
    parameter int NUM_EP = 4,
    parameter int EP_W   = 4,
    parameter int DATA_W = 8
);
    // Handshake: a strobe (TxFifoREn/RxFifoWEn) moves one word on a clock edge only when the
    // matching per-endpoint enable is high in that cycle; the enable is the strobe qualified by
    // the combinational ready terms (not empty / not full / byte cap), with zero latency.
    logic                       transStart;
    logic                       transEnd;
    logic [EP_W-1:0]            currEndP;
    logic                       TxFifoREn;
    logic [DATA_W-1:0]          TxFifoData;
    logic                       TxFifoEmpty;
    logic                       RxFifoWEn;
    logic                       RxFifoFull;
    logic [NUM_EP-1:0]          TxFifoEPREn;
    logic [NUM_EP*DATA_W-1:0]   TxFifoEPData;
    logic [NUM_EP-1:0]          TxFifoEPEmpty;
    logic [NUM_EP-1:0]          RxFifoEPWEn;
    logic [NUM_EP-1:0]          RxFifoEPFull;

    modport master (
        output transStart, transEnd, currEndP, TxFifoREn, RxFifoWEn,
        output TxFifoEPData, TxFifoEPEmpty, RxFifoEPFull,
        input  TxFifoData, TxFifoEmpty, RxFifoFull, TxFifoEPREn, RxFifoEPWEn
    );

    modport slave (
        input  transStart, transEnd, currEndP, TxFifoREn, RxFifoWEn,
        input  TxFifoEPData, TxFifoEPEmpty, RxFifoEPFull,
        output TxFifoData, TxFifoEmpty, RxFifoFull, TxFifoEPREn, RxFifoEPWEn
    );
endinterface

// File: rtl/usb_endp_fifo_mux.sv
// N-endpoint FIFO multiplexer: latches the endpoint per transaction, steers strobes, counts bytes.
// Optional per-endpoint transaction/error statistics under macro USB_ENDP_MUX_STATS_EN.
module usb_endp_fifo_mux #(
    parameter int NUM_EP  = 4,
    parameter int EP_W    = 4,
    parameter int DATA_W  = 8,
    parameter int MAX_PKT = 64,
    parameter int CNT_W   = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    usb_endp_fifo_mux_if.slave   bus,
    output logic                 busy,
    output logic [EP_W-1:0]      selEndP,
    output logic                 epValid,
    output logic [CNT_W-1:0]     txByteCnt,
    output logic [CNT_W-1:0]     rxByteCnt,
    output logic                 txUnderrun,
    output logic                 rxBabble,
    output logic                 dbg_state
`ifdef USB_ENDP_MUX_STATS_EN
    ,
    input  logic [EP_W-1:0]      statSel,
    output logic [15:0]          statTransCnt,
    output logic [15:0]          statErrCnt
`endif
);
    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_PKT);
    localparam logic [EP_W:0]    NUM_EP_L = (EP_W+1)'(NUM_EP);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] sel_data;
    logic              sel_empty, sel_full;
    logic              rx_cap, tx_issue, rx_issue, tx_fail, rx_fail;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // A transStart always (re)opens a transaction, so it wins over a coincident transEnd.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.transStart) state_d = ACTIVE;
            ACTIVE:  if (bus.transStart) state_d = ACTIVE;
                     else if (bus.transEnd) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q == ACTIVE);
    assign dbg_state = (state_q == ACTIVE);

    // An invalid endpoint looks like an empty Tx FIFO and a full Rx FIFO.
    always_comb begin
        sel_data  = '0;
        sel_empty = 1'b1;
        sel_full  = 1'b1;
        for (int k = 0; k < NUM_EP; k++) begin
            if (epValid && (selEndP == EP_W'(k))) begin
                sel_data  = bus.TxFifoEPData[k*DATA_W +: DATA_W];
                sel_empty = bus.TxFifoEPEmpty[k];
                sel_full  = bus.RxFifoEPFull[k];
            end
        end
    end

    assign rx_cap   = !(rxByteCnt < MAX_CNT);
    assign tx_issue = bus.TxFifoREn & busy & ~sel_empty;
    assign rx_issue = bus.RxFifoWEn & busy & ~sel_full & ~rx_cap;
    assign tx_fail  = bus.TxFifoREn & busy & ~tx_issue;
    assign rx_fail  = bus.RxFifoWEn & busy & ~rx_issue;

    assign bus.TxFifoData  = sel_data;
    assign bus.TxFifoEmpty = sel_empty;
    assign bus.RxFifoFull  = sel_full | rx_cap;

    always_comb begin
        bus.TxFifoEPREn = '0;
        bus.RxFifoEPWEn = '0;
        for (int k = 0; k < NUM_EP; k++) begin
            bus.TxFifoEPREn[k] = tx_issue & (selEndP == EP_W'(k));
            bus.RxFifoEPWEn[k] = rx_issue & (selEndP == EP_W'(k));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            selEndP    <= '0;
            epValid    <= 1'b0;
            txByteCnt  <= '0;
            rxByteCnt  <= '0;
            txUnderrun <= 1'b0;
            rxBabble   <= 1'b0;
        end else if (bus.transStart) begin
            selEndP    <= bus.currEndP;
            epValid    <= ({1'b0, bus.currEndP} < NUM_EP_L);
            txByteCnt  <= '0;
            rxByteCnt  <= '0;
            txUnderrun <= 1'b0;
            rxBabble   <= 1'b0;
        end else if (busy) begin
            // Reads past the cap still go through; only the count saturates.
            if (tx_issue && (txByteCnt != MAX_CNT)) txByteCnt <= txByteCnt + 1'b1;
            if (rx_issue) rxByteCnt <= rxByteCnt + 1'b1;
            if (tx_fail)  txUnderrun <= 1'b1;
            if (rx_fail)  rxBabble   <= 1'b1;
        end
    end

`ifdef USB_ENDP_MUX_STATS_EN
    logic [15:0] trans_cnt [NUM_EP];
    logic [15:0] err_cnt   [NUM_EP];
    logic        close_now, err_now;

    // A closing cycle's own failed strobe still counts against the transaction being closed.
    assign close_now = busy & (bus.transStart | bus.transEnd) & epValid;
    assign err_now   = txUnderrun | rxBabble | tx_fail | rx_fail;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_EP; k++) begin
                trans_cnt[k] <= '0;
                err_cnt[k]   <= '0;
            end
        end else if (close_now) begin
            for (int k = 0; k < NUM_EP; k++) begin
                if (selEndP == EP_W'(k)) begin
                    trans_cnt[k] <= trans_cnt[k] + 16'd1;
                    if (err_now) err_cnt[k] <= err_cnt[k] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        statTransCnt = '0;
        statErrCnt   = '0;
        for (int k = 0; k < NUM_EP; k++) begin
            if (statSel == EP_W'(k)) begin
                statTransCnt = trans_cnt[k];
                statErrCnt   = err_cnt[k];
            end
        end
    end
`endif

endmodule

// File: tb/tb_usb_endp_fifo_mux.sv
// Directed bench for usb_endp_fifo_mux with a transaction-level reference model and per-cycle compare.
module tb_usb_endp_fifo_mux;
    localparam int NUM_EP  = 4;
    localparam int EP_W    = 4;
    localparam int DATA_W  = 8;
    localparam int MAX_PKT = 64;
    localparam int CNT_W   = 7;

    logic              clk;
    logic              rst_n;
    logic              busy, epValid, txUnderrun, rxBabble, dbg_state;
    logic [EP_W-1:0]   selEndP;
    logic [CNT_W-1:0]  txByteCnt, rxByteCnt;
`ifdef USB_ENDP_MUX_STATS_EN
    logic [EP_W-1:0]   statSel;
    logic [15:0]       statTransCnt, statErrCnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic cmp_en = 1'b0;

    usb_endp_fifo_mux_if #(.NUM_EP(NUM_EP), .EP_W(EP_W), .DATA_W(DATA_W)) bus ();

    usb_endp_fifo_mux #(
        .NUM_EP(NUM_EP), .EP_W(EP_W), .DATA_W(DATA_W), .MAX_PKT(MAX_PKT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .busy(busy), .selEndP(selEndP), .epValid(epValid),
        .txByteCnt(txByteCnt), .rxByteCnt(rxByteCnt),
        .txUnderrun(txUnderrun), .rxBabble(rxBabble), .dbg_state(dbg_state)
`ifdef USB_ENDP_MUX_STATS_EN
        , .statSel(statSel), .statTransCnt(statTransCnt), .statErrCnt(statErrCnt)
`endif
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: transaction state kept as plain integers
    logic m_busy, m_valid, m_und, m_bab;
    int   m_sel, m_tx, m_rx;
    int   m_trans [NUM_EP];
    int   m_err   [NUM_EP];
    logic m_rd, m_wr, m_rfail, m_wfail;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_valid = 0; m_und = 0; m_bab = 0;
            m_sel = 0; m_tx = 0; m_rx = 0;
            for (int k = 0; k < NUM_EP; k++) begin
                m_trans[k] = 0;
                m_err[k]   = 0;
            end
        end else begin
            m_rd = 0; m_wr = 0; m_rfail = 0; m_wfail = 0;
            if (m_busy) begin
                m_rd    = bus.TxFifoREn && m_valid && !bus.TxFifoEPEmpty[m_sel];
                m_rfail = bus.TxFifoREn && !m_rd;
                m_wr    = bus.RxFifoWEn && m_valid && !bus.RxFifoEPFull[m_sel] && (m_rx < MAX_PKT);
                m_wfail = bus.RxFifoWEn && !m_wr;
            end
            if (m_busy && m_valid && (bus.transStart || bus.transEnd)) begin
                m_trans[m_sel] = (m_trans[m_sel] + 1) % 65536;
                if (m_und || m_bab || m_rfail || m_wfail)
                    m_err[m_sel] = (m_err[m_sel] + 1) % 65536;
            end
            if (bus.transStart) begin
                m_busy  = 1;
                m_sel   = int'(bus.currEndP);
                m_valid = (m_sel < NUM_EP);
                m_tx = 0; m_rx = 0; m_und = 0; m_bab = 0;
            end else if (m_busy) begin
                if (m_rd && m_tx < MAX_PKT) m_tx++;
                if (m_wr) m_rx++;
                if (m_rfail) m_und = 1;
                if (m_wfail) m_bab = 1;
                if (bus.transEnd) m_busy = 0;
            end
        end
    end

    // scoreboard: compare every DUT output against the model each cycle
    logic [3:0]        one4;
    logic [3:0]        e_ren, e_wen;
    logic              e_empty, e_full;
    logic [DATA_W-1:0] e_data;
    always @(negedge clk) begin
        if (cmp_en) begin
            one4    = 4'b0001;
            e_empty = m_valid ? bus.TxFifoEPEmpty[m_sel] : 1'b1;
            e_data  = m_valid ? bus.TxFifoEPData[m_sel*DATA_W +: DATA_W] : '0;
            e_full  = m_valid ? (bus.RxFifoEPFull[m_sel] || m_rx == MAX_PKT) : 1'b1;
            e_ren   = (m_busy && bus.TxFifoREn && !e_empty) ? (one4 << m_sel) : 4'b0000;
            e_wen   = (m_busy && bus.RxFifoWEn && m_valid && !bus.RxFifoEPFull[m_sel]
                       && m_rx < MAX_PKT) ? (one4 << m_sel) : 4'b0000;
            check("cmp_busy",    busy,            m_busy);
            check("cmp_sel",     selEndP,         m_sel);
            check("cmp_valid",   epValid,         m_valid);
            check("cmp_txcnt",   txByteCnt,       m_tx);
            check("cmp_rxcnt",   rxByteCnt,       m_rx);
            check("cmp_und",     txUnderrun,      m_und);
            check("cmp_bab",     rxBabble,        m_bab);
            check("cmp_txdata",  bus.TxFifoData,  e_data);
            check("cmp_txempty", bus.TxFifoEmpty, e_empty);
            check("cmp_rxfull",  bus.RxFifoFull,  e_full);
            check("cmp_ren",     bus.TxFifoEPREn, e_ren);
            check("cmp_wen",     bus.RxFifoEPWEn, e_wen);
`ifdef USB_ENDP_MUX_STATS_EN
            check("cmp_stat_trans", statTransCnt, (int'(statSel) < NUM_EP) ? m_trans[statSel] : 0);
            check("cmp_stat_err",   statErrCnt,   (int'(statSel) < NUM_EP) ? m_err[statSel]   : 0);
`endif
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_tr(input int ep);
        bus.currEndP   = EP_W'(ep);
        bus.transStart = 1'b1;
        step();
        bus.transStart = 1'b0;
    endtask

    task automatic end_tr();
        bus.transEnd = 1'b1;
        step();
        bus.transEnd = 1'b0;
    endtask

    int wr_seen;

    initial begin
        rst_n = 1'b1;
        bus.transStart = 0; bus.transEnd = 0; bus.currEndP = '0;
        bus.TxFifoREn = 0; bus.RxFifoWEn = 0;
        bus.TxFifoEPData  = 32'h44332211;
        bus.TxFifoEPEmpty = 4'b0000;
        bus.RxFifoEPFull  = 4'b0000;
`ifdef USB_ENDP_MUX_STATS_EN
        statSel = 4'd1;
`endif
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_sel", selEndP, 0);
        check("rst_valid", epValid, 0);
        check("rst_txcnt", txByteCnt, 0);
        check("rst_rxcnt", rxByteCnt, 0);
        check("rst_flags", {txUnderrun, rxBabble}, 2'b00);
        check("rst_en", {bus.TxFifoEPREn, bus.RxFifoEPWEn}, 8'h00);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        step();

        // five reads from EP2
        start_tr(2);
        check("t1_busy", busy, 1);
        for (int i = 0; i < 5; i++) begin
            bus.TxFifoREn = 1'b1;
            #1 check("t1_ren", bus.TxFifoEPREn, 4'b0100);
            check("t1_data", bus.TxFifoData, 8'h33);
            step();
        end
        bus.TxFifoREn = 1'b0;
        check("t1_txcnt", txByteCnt, 5);
        check("t1_busy2", busy, 1);
        end_tr();
        check("t1_idle", busy, 0);
        check("t1_hold", txByteCnt, 5);

        // strobes while idle are ignored
        bus.TxFifoREn = 1'b1; bus.RxFifoWEn = 1'b1;
        #1 check("idle_en", {bus.TxFifoEPREn, bus.RxFifoEPWEn}, 8'h00);
        step();
        bus.TxFifoREn = 1'b0; bus.RxFifoWEn = 1'b0;
        check("idle_flags", {txUnderrun, rxBabble}, 2'b00);
        check("idle_hold", txByteCnt, 5);

        // out-of-range endpoint
        start_tr(7);
        bus.TxFifoREn = 1'b1; bus.RxFifoWEn = 1'b1;
        #1 check("t2_valid", epValid, 0);
        check("t2_en", {bus.TxFifoEPREn, bus.RxFifoEPWEn}, 8'h00);
        check("t2_empty", bus.TxFifoEmpty, 1);
        check("t2_data", bus.TxFifoData, 0);
        check("t2_full", bus.RxFifoFull, 1);
        step();
        bus.TxFifoREn = 1'b0; bus.RxFifoWEn = 1'b0;
        check("t2_flags", {txUnderrun, rxBabble}, 2'b11);
        end_tr();
        check("t2_flags_hold", {txUnderrun, rxBabble}, 2'b11);

        // 66 writes to EP1 against the 64-byte cap
        start_tr(1);
        check("t3_cleared", {txUnderrun, rxBabble}, 2'b00);
        wr_seen = 0;
        for (int i = 0; i < 66; i++) begin
            bus.RxFifoWEn = 1'b1;
            #1;
            if (i == 64) begin
                check("t3_bab_before", rxBabble, 0);
                check("t3_full", bus.RxFifoFull, 1);
                check("t3_rxcnt64", rxByteCnt, 64);
            end
            if (bus.RxFifoEPWEn == 4'b0010) wr_seen++;
            step();
        end
        bus.RxFifoWEn = 1'b0;
        check("t3_writes", wr_seen, 64);
        check("t3_rxcnt", rxByteCnt, 64);
        check("t3_bab", rxBabble, 1);
        end_tr();

        // write into a full endpoint FIFO
        start_tr(2);
        bus.RxFifoEPFull = 4'b0100;
        bus.RxFifoWEn = 1'b1;
        #1 check("t3b_wen", bus.RxFifoEPWEn, 4'b0000);
        check("t3b_full", bus.RxFifoFull, 1);
        step();
        bus.RxFifoWEn = 1'b0;
        bus.RxFifoEPFull = 4'b0000;
        check("t3b_bab", rxBabble, 1);
        check("t3b_rxcnt", rxByteCnt, 0);
        end_tr();

        // tx count saturates but reads are not suppressed
        start_tr(0);
        for (int i = 0; i < 66; i++) begin
            bus.TxFifoREn = 1'b1;
            #1;
            if (i == 64) begin
                check("t3c_ren_past_cap", bus.TxFifoEPREn, 4'b0001);
                check("t3c_txcnt64", txByteCnt, 64);
            end
            step();
        end
        bus.TxFifoREn = 1'b0;
        check("t3c_txcnt", txByteCnt, 64);
        check("t3c_und", txUnderrun, 0);
        end_tr();

        // start+end together during an EP3 transaction
        start_tr(3);
        bus.TxFifoREn = 1'b1;
        step();
        step();
        bus.TxFifoREn = 1'b0;
        check("t4_txcnt", txByteCnt, 2);
        check("t4_data", bus.TxFifoData, 8'h44);
        bus.currEndP = 4'd0; bus.transStart = 1'b1; bus.transEnd = 1'b1;
        step();
        bus.transStart = 1'b0; bus.transEnd = 1'b0;
        check("t4_sel", selEndP, 0);
        check("t4_txcnt0", txByteCnt, 0);
        check("t4_busy", busy, 1);

        // asynchronous reset mid-transfer
        bus.TxFifoREn = 1'b1;
        #1 check("t5_ren_before", bus.TxFifoEPREn, 4'b0001);
        #1 rst_n = 1'b0;
        #1 check("t5_ren", bus.TxFifoEPREn, 4'b0000);
        check("t5_busy", busy, 0);
        check("t5_regs", {selEndP, epValid, txByteCnt, rxByteCnt, txUnderrun, rxBabble}, 0);
        check("t5_empty", bus.TxFifoEmpty, 1);
        bus.TxFifoREn = 1'b0;
        step();
        rst_n = 1'b1;
        step();

`ifdef USB_ENDP_MUX_STATS_EN
        for (int t = 0; t < 3; t++) begin
            start_tr(1);
            bus.TxFifoREn = 1'b1;
            step();
            bus.TxFifoREn = 1'b0;
            end_tr();
        end
        bus.TxFifoEPEmpty = 4'b0010;
        start_tr(1);
        bus.TxFifoREn = 1'b1;
        step();
        bus.TxFifoREn = 1'b0;
        end_tr();
        bus.TxFifoEPEmpty = 4'b0000;
        statSel = 4'd1;
        #1 check("t6_trans", statTransCnt, 4);
        check("t6_err", statErrCnt, 1);
        statSel = 4'd9;
        #1 check("t6_oor", {statTransCnt, statErrCnt}, 0);
        statSel = 4'd1;
        start_tr(1);
        start_tr(2);
        end_tr();
        check("t6_implicit", statTransCnt, 5);
`endif

        step();
        step();
        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/usb_endp_fifo_mux.md
Name: usb_endp_fifo_mux

Overview:
- Parametrised N-endpoint FIFO multiplexer for the USB slave controller.
- Sits between the slave send/get packet engines and the per-endpoint Tx/Rx FIFOs.
- Latches the target endpoint for a whole transaction, steers read/write strobes, and counts bytes per transaction.
- Enforces the max-packet limit and flags underrun/babble; replaces the fixed 4-endpoint combinational mux.

Parameters:
- NUM_EP, 4, number of endpoints (1..16).
- EP_W, 4, width of endpoint index input (USB endpoint field).
- DATA_W, 8, FIFO data width.
- MAX_PKT, 64, max bytes per transaction per direction.
- CNT_W, 7, byte counter width; must satisfy 2^CNT_W > MAX_PKT.

Ports:
- clk  in  1  USB clock.
- rst_n  in  1  async active-low reset.
- transStart  in  1  pulse: latch currEndP, begin transaction.
- transEnd  in  1  pulse: close transaction.
- currEndP  in  EP_W  endpoint number from token.
- TxFifoREn  in  1  read strobe from send engine.
- TxFifoData  out  DATA_W  muxed Tx data.
- TxFifoEmpty  out  1  muxed Tx empty.
- RxFifoWEn  in  1  write strobe from get engine.
- RxFifoFull  out  1  muxed Rx full.
- TxFifoEPREn  out  NUM_EP  per-endpoint read enables.
- TxFifoEPData  in  NUM_EP*DATA_W  endpoint k at [k*DATA_W +: DATA_W].
- TxFifoEPEmpty  in  NUM_EP  per-endpoint empty.
- RxFifoEPWEn  out  NUM_EP  per-endpoint write enables.
- RxFifoEPFull  in  NUM_EP  per-endpoint full.
- busy  out  1  transaction active.
- selEndP  out  EP_W  latched endpoint.
- epValid  out  1  latched endpoint < NUM_EP.
- txByteCnt  out  CNT_W  bytes read this transaction.
- rxByteCnt  out  CNT_W  bytes written this transaction.
- txUnderrun  out  1  sticky: read attempted while empty.
- rxBabble  out  1  sticky: write attempted at MAX_PKT or while full.

Behaviour:
- Reset (rst_n low, async): state IDLE.
  - busy=0, selEndP=0, epValid=0, both counters=0, txUnderrun=0, rxBabble=0.
  - All per-endpoint enables=0.
- FSM IDLE -> ACTIVE on transStart.
  - Same edge: selEndP<=currEndP, epValid<=(currEndP<NUM_EP).
  - Counters and sticky flags cleared; busy=1 from next cycle.
- ACTIVE -> IDLE on transEnd. selEndP, counters and flags hold their values until the next transStart.
- transStart in ACTIVE: treated as an implicit end plus restart. The new endpoint is latched and counters/flags are cleared on that edge; state stays ACTIVE.
- transStart and transEnd in the same cycle: transStart wins.
- Strobe steering is combinational, zero latency:
  - TxFifoEPREn[k] = TxFifoREn & busy & epValid & (selEndP==k) & ~TxFifoEPEmpty[k].
  - RxFifoEPWEn[k] = RxFifoWEn & busy & epValid & (selEndP==k) & ~RxFifoEPFull[k] & (rxByteCnt<MAX_PKT).
- Muxed outputs (combinational from selEndP):
  - TxFifoData = selected endpoint's data, or 0 if !epValid.
  - TxFifoEmpty = selected endpoint's empty, or 1 if !epValid.
  - RxFifoFull = selected full | (rxByteCnt==MAX_PKT), or 1 if !epValid.
- txByteCnt increments on each issued endpoint read and saturates at MAX_PKT. A read at MAX_PKT is not suppressed, but the count does not wrap.
- rxByteCnt increments on each issued endpoint write; writes at MAX_PKT are blocked.
- txUnderrun set when TxFifoREn=1 in ACTIVE and the read is suppressed (empty or !epValid).
- rxBabble set when RxFifoWEn=1 in ACTIVE and the write is suppressed (full, cap reached, or !epValid).
- Strobes in IDLE: ignored, no flags set.
- Reset asserted mid-transaction: immediate return to reset values; enables drop asynchronously.

Optional Feature:
- Macro USB_ENDP_MUX_STATS_EN.
- Defined:
  - Adds input statSel (EP_W) and outputs statTransCnt (16) and statErrCnt (16).
  - Per endpoint, a 16-bit wrapping counter increments on each transEnd (or implicit end) closing a transaction on that endpoint.
  - A second 16-bit wrapping counter increments when that transaction ended with txUnderrun or rxBabble set.
  - Outputs show the counters of endpoint statSel, combinationally; 0 for out-of-range statSel.
  - Counters reset to 0 by rst_n.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset, then transStart with currEndP=2 and 5 TxFifoREn pulses, EP2 not empty:
  - TxFifoEPREn=4'b0100 on each pulse, txByteCnt=5, busy=1.
  - After transEnd, busy=0 and txByteCnt holds 5.
- currEndP=7 with NUM_EP=4, then TxFifoREn and RxFifoWEn:
  - epValid=0, no enables, TxFifoEmpty=1, TxFifoData=0.
  - txUnderrun=1, rxBabble=1.
- EP1 Rx, 66 consecutive RxFifoWEn with MAX_PKT=64:
  - 64 writes issued, rxByteCnt=64, RxFifoFull=1.
  - rxBabble set on write 65.
- transStart(EP0) and transEnd asserted together during an EP3 transaction:
  - selEndP=0, counters cleared, busy stays 1.
- rst_n pulled low mid-transfer while TxFifoREn is high:
  - TxFifoEPREn=0 immediately, all outputs at reset values.
- With USB_ENDP_MUX_STATS_EN: 3 clean transactions on EP1, then 1 underrun transaction on EP1:
  - statSel=1 gives statTransCnt=4, statErrCnt=1.
